// File: rtl/afilter_pkg.sv
`default_nettype none
// ============================================================================
// afilter_pkg : state encoding, gain constant and helpers for afilter_sequencer
// Rev 1.0
// ============================================================================
package afilter_pkg;

    localparam int STATE_W = 3;

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_DEBOUNCE = 3'd1;
    localparam logic [2:0] S_RAMP_DN  = 3'd2;
    localparam logic [2:0] S_SWITCH   = 3'd3;
    localparam logic [2:0] S_CLEAR    = 3'd4;
    localparam logic [2:0] S_SETTLE   = 3'd5;
    localparam logic [2:0] S_RAMP_UP  = 3'd6;

    localparam logic [7:0] GAIN_UNITY = 8'd128;

    function automatic logic is_busy(input logic [STATE_W-1:0] st);
        return !((st == S_IDLE) || (st == S_DEBOUNCE));
    endfunction

endpackage
`default_nettype wire

// File: rtl/afilter_sync2.sv
`default_nettype none
// ============================================================================
// afilter_sync2 : two-flop synchronizer for a quasi-static multi-bit selector
// Rev 1.0
// ============================================================================
module afilter_sync2 #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule
`default_nettype wire

// File: rtl/afilter_sequencer.sv
`default_nettype none
// ============================================================================
// afilter_sequencer : debounced, click-free filter switch (mute ramp, table
// swap, IIR clear + settle, unmute ramp). Rev 1.0
// ============================================================================
module afilter_sequencer
    import afilter_pkg::*;
#(
    parameter int STABLE_CYC     = 1024,
    parameter int SETTLE_SAMPLES = 64,
    parameter int RAMP_STEP      = 4,
    parameter int TBL_LAT        = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] afilter_sw,
    input  logic       sample_tick,
    output logic [3:0] tbl_sel,
    output logic       flt_load,
    output logic       flt_clr,
    output logic [7:0] gain,
    output logic       busy
);

    localparam int CYC_MAX = (STABLE_CYC > TBL_LAT + 1) ? STABLE_CYC : TBL_LAT + 1;
    localparam int CYC_W   = $clog2(CYC_MAX + 1);
    localparam int SMP_W   = $clog2(SETTLE_SAMPLES + 1);

    localparam logic [CYC_W-1:0] STABLE_LAST = CYC_W'(STABLE_CYC - 1);
    localparam logic [CYC_W-1:0] SWITCH_LAST = CYC_W'(TBL_LAT);
    localparam logic [SMP_W-1:0] SETTLE_LAST = SMP_W'(SETTLE_SAMPLES - 1);
    localparam logic [8:0]       STEP9       = 9'(RAMP_STEP);

    logic [3:0]       sw_s;
    logic [2:0]       state_q,   state_d;
    logic [3:0]       cand_q,    cand_d;
    logic [CYC_W-1:0] cyc_q,     cyc_d;
    logic [SMP_W-1:0] smp_q,     smp_d;
    logic [7:0]       gain_q,    gain_d;
    logic [3:0]       tbl_sel_q, tbl_sel_d;
    logic             pulse_d;
    logic             flt_load_q, flt_clr_q, busy_q;
    logic [7:0]       gain_dn, gain_up;

    afilter_sync2 #(
        .WIDTH (4)
    ) u_sync (
        .clk   (clk),
        .reset (reset),
        .d_i   (afilter_sw),
        .q_o   (sw_s)
    );

    // 9-bit arithmetic so a step that does not divide 128 saturates instead of wrapping
    assign gain_dn = ({1'b0, gain_q} > STEP9) ? 8'({1'b0, gain_q} - STEP9) : 8'd0;
    assign gain_up = (({1'b0, gain_q} + STEP9) >= {1'b0, GAIN_UNITY})
                     ? GAIN_UNITY : 8'({1'b0, gain_q} + STEP9);

    always_comb begin
        state_d   = state_q;
        cand_d    = cand_q;
        cyc_d     = cyc_q;
        smp_d     = smp_q;
        gain_d    = gain_q;
        tbl_sel_d = tbl_sel_q;
        pulse_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (sw_s != tbl_sel_q) begin
                    cand_d  = sw_s;
                    cyc_d   = '0;
                    state_d = S_DEBOUNCE;
                end
            end
            S_DEBOUNCE: begin
                if (sw_s == tbl_sel_q) begin
                    state_d = S_IDLE;
                end else if (sw_s != cand_q) begin
                    cand_d = sw_s;
                    cyc_d  = '0;
                end else if (cyc_q == STABLE_LAST) begin
                    state_d = S_RAMP_DN;
                end else begin
                    cyc_d = cyc_q + CYC_W'(1);
                end
            end
            S_RAMP_DN: begin
                if (gain_q == 8'd0) begin
                    state_d   = S_SWITCH;
                    tbl_sel_d = cand_q;
                    cyc_d     = '0;
                end else if (sample_tick) begin
                    gain_d = gain_dn;
                end
            end
            S_SWITCH: begin
                // Table output is valid TBL_LAT cycles after tbl_sel; one extra cycle of margin
                if (cyc_q == SWITCH_LAST) begin
                    state_d = S_CLEAR;
                    pulse_d = 1'b1;
                end else begin
                    cyc_d = cyc_q + CYC_W'(1);
                end
            end
            S_CLEAR: begin
                smp_d   = '0;
                state_d = S_SETTLE;
            end
            S_SETTLE: begin
                if (sample_tick) begin
                    if (smp_q == SETTLE_LAST) begin
                        state_d = S_RAMP_UP;
                    end else begin
                        smp_d = smp_q + SMP_W'(1);
                    end
                end
            end
            S_RAMP_UP: begin
                if (gain_q == GAIN_UNITY) begin
                    state_d = S_IDLE;
                end else if (sample_tick) begin
                    gain_d = gain_up;
                end
            end
            default: state_d = S_SWITCH;
        endcase
    end

    // Reset lands in SWITCH with cand=0 so the power-up load/unmute reuses the normal path
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_SWITCH;
            cand_q     <= '0;
            cyc_q      <= '0;
            smp_q      <= '0;
            gain_q     <= 8'd0;
            tbl_sel_q  <= '0;
            flt_load_q <= 1'b0;
            flt_clr_q  <= 1'b0;
            busy_q     <= 1'b1;
        end else begin
            state_q    <= state_d;
            cand_q     <= cand_d;
            cyc_q      <= cyc_d;
            smp_q      <= smp_d;
            gain_q     <= gain_d;
            tbl_sel_q  <= tbl_sel_d;
            flt_load_q <= pulse_d;
            flt_clr_q  <= pulse_d;
            busy_q     <= is_busy(state_d);
        end
    end

    assign tbl_sel  = tbl_sel_q;
    assign flt_load = flt_load_q;
    assign flt_clr  = flt_clr_q;
    assign gain     = gain_q;
    assign busy     = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_afilter_sequencer.sv
`default_nettype none
// ============================================================================
// tb_afilter_sequencer : directed bench for afilter_sequencer (step 32 and 48)
// Rev 1.0
// ============================================================================
module tb_afilter_sequencer;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       reset2 = 1'b1;
    logic [3:0] sw = 4'd0;
    logic [3:0] sw2 = 4'd0;
    logic       sample_tick = 1'b0;
    logic [3:0] tbl_sel, tbl_sel2;
    logic       flt_load, flt_clr, flt_load2, flt_clr2;
    logic [7:0] gain, gain2;
    logic       busy, busy2;

    int n_checks = 0;
    int n_fail   = 0;

    afilter_sequencer #(
        .STABLE_CYC (8), .SETTLE_SAMPLES (4), .RAMP_STEP (32), .TBL_LAT (1)
    ) dut (
        .clk (clk), .reset (reset), .afilter_sw (sw), .sample_tick (sample_tick),
        .tbl_sel (tbl_sel), .flt_load (flt_load), .flt_clr (flt_clr),
        .gain (gain), .busy (busy)
    );

    afilter_sequencer #(
        .STABLE_CYC (8), .SETTLE_SAMPLES (4), .RAMP_STEP (48), .TBL_LAT (1)
    ) dut48 (
        .clk (clk), .reset (reset2), .afilter_sw (sw2), .sample_tick (sample_tick),
        .tbl_sel (tbl_sel2), .flt_load (flt_load2), .flt_clr (flt_clr2),
        .gain (gain2), .busy (busy2)
    );

    initial forever #5 clk = ~clk;

    // Monitor state: written only by the monitor process below
    logic [7:0] glog[$];
    logic [7:0] glog2[$];
    logic [7:0] g_prev = 8'd0, g2_prev = 8'd0, tsel_gain = 8'hFF;
    logic [3:0] tsel_prev = 4'd0;
    int n_load = 0, n_clr = 0, n_busy = 0, n_load2 = 0, n_pair = 0;
    int tick_cnt = 0, st_cnt = 0, settle_ticks = -1;
    bit st_on = 0, st_skip = 0, prev_tick = 0;

    initial forever begin
        @(negedge clk);
        prev_tick = sample_tick;
        if (gain != g_prev) begin glog.push_back(gain); g_prev = gain; end
        if (gain2 != g2_prev) begin glog2.push_back(gain2); g2_prev = gain2; end
        if (flt_load) n_load++;
        if (flt_clr) n_clr++;
        if (flt_load2) n_load2++;
        if (flt_load != flt_clr || flt_load2 != flt_clr2) n_pair++;
        if (busy) n_busy++;
        if (tbl_sel != tsel_prev) begin tsel_gain = gain; tsel_prev = tbl_sel; end
        // Ticks from after the CLEAR cycle up to and including the first unmute step
        if (flt_clr) begin
            st_on = 1; st_skip = 1; st_cnt = 0;
        end else if (st_on) begin
            if (st_skip) st_skip = 0;
            else begin
                if (prev_tick) st_cnt++;
                if (gain != 8'd0) begin st_on = 0; settle_ticks = st_cnt; end
            end
        end
        tick_cnt = (tick_cnt == 9) ? 0 : tick_cnt + 1;
        sample_tick = (tick_cnt == 0);
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin @(negedge clk); #1; end
    endtask

    function automatic logic [7:0] obs_sel(input int sel);
        case (sel)
            0:       return {7'd0, busy};
            1:       return {7'd0, flt_clr};
            2:       return {7'd0, busy2};
            default: return gain;
        endcase
    endfunction

    task automatic wait_for(input string tag, input int sel, input logic [7:0] val,
                            input int max_cyc, output int cyc);
        cyc = 0;
        while (cyc < max_cyc && obs_sel(sel) !== val) begin
            step(1);
            cyc++;
        end
        check_val(tag, {24'd0, obs_sel(sel)}, {24'd0, val});
    endtask

    task automatic check_log(input string tag, input bit which, input int base,
                             input int n, input logic [7:0] e [8]);
        int sz;
        logic [31:0] obs;
        sz = which ? glog2.size() : glog.size();
        check_val({tag, "_len"}, sz - base, n);
        for (int i = 0; i < n; i++) begin
            obs = 32'hFFFF;
            if (base + i < sz) obs = {24'd0, which ? glog2[base + i] : glog[base + i]};
            check_val($sformatf("%s[%0d]", tag, i), obs, {24'd0, e[i]});
        end
    endtask

    int cyc, b_log, b_load, b_clr, b_busy, b_log2, b_load2;
    logic [7:0] e_up [8];
    logic [7:0] e_full [8];
    logic [7:0] e48_up [8];
    logic [7:0] e48_full [8];

    task automatic snap();
        b_log = glog.size(); b_load = n_load; b_clr = n_clr; b_busy = n_busy;
        b_log2 = glog2.size(); b_load2 = n_load2;
    endtask

    initial begin
        e_up     = '{8'd32, 8'd64, 8'd96, 8'd128, 8'd0, 8'd0, 8'd0, 8'd0};
        e_full   = '{8'd96, 8'd64, 8'd32, 8'd0, 8'd32, 8'd64, 8'd96, 8'd128};
        e48_up   = '{8'd48, 8'd96, 8'd128, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
        e48_full = '{8'd80, 8'd32, 8'd0, 8'd48, 8'd96, 8'd128, 8'd0, 8'd0};

        // Reset values
        step(3);
        check_val("rst_tbl_sel", tbl_sel, 0);
        check_val("rst_gain", gain, 0);
        check_val("rst_busy", busy, 1);
        check_val("rst_load", flt_load, 0);
        check_val("rst_clr", flt_clr, 0);

        // Power-up sequence: load, settle, unmute to unity with selection 0
        snap();
        reset = 1'b0; reset2 = 1'b0;
        wait_for("pwr_busy_fall", 0, 8'd0, 300, cyc);
        check_val("pwr_load", n_load - b_load, 1);
        check_val("pwr_clr", n_clr - b_clr, 1);
        check_val("pwr_settle_ticks", settle_ticks, 5);
        check_log("pwr_gain", 1'b0, b_log, 4, e_up);
        check_val("pwr_tbl_sel", tbl_sel, 0);

        // Short glitch on the switch is rejected by the debouncer
        snap();
        sw = 4'd5;
        step(5);
        sw = 4'd0;
        step(40);
        check_val("glitch_busy_cycles", n_busy - b_busy, 0);
        check_val("glitch_load", n_load - b_load, 0);
        check_val("glitch_gain_changes", glog.size() - b_log, 0);
        check_val("glitch_gain", gain, 128);

        // 0 -> 3: 2 sync + 1 IDLE + 8 DEBOUNCE cycles before the mute ramp starts
        snap();
        sw = 4'd3;
        wait_for("sw3_busy_rise", 0, 8'd1, 100, cyc);
        check_val("sw3_latency", cyc, 11);
        wait_for("sw3_clr", 1, 8'd1, 300, cyc);
        step(3);
        sw = 4'd7;  // request lands in SETTLE and must not disturb this sequence
        wait_for("sw3_busy_fall", 0, 8'd0, 400, cyc);
        check_val("sw3_tbl_sel", tbl_sel, 3);
        check_val("sw3_gain_at_swap", tsel_gain, 0);
        check_val("sw3_load", n_load - b_load, 1);
        check_val("sw3_clr", n_clr - b_clr, 1);
        check_val("sw3_settle_ticks", settle_ticks, 5);
        check_log("sw3_gain", 1'b0, b_log, 8, e_full);

        // Deferred request 7 is picked up from IDLE as a second sequence
        snap();
        wait_for("sw7_busy_rise", 0, 8'd1, 100, cyc);
        wait_for("sw7_busy_fall", 0, 8'd0, 400, cyc);
        check_val("sw7_tbl_sel", tbl_sel, 7);
        check_val("sw7_load", n_load - b_load, 1);
        check_log("sw7_gain", 1'b0, b_log, 8, e_full);

        // Reset mid ramp-down at gain 64
        sw = 4'd0;
        wait_for("rdn_gain64", 3, 8'd64, 300, cyc);
        #2 reset = 1'b1;
        #1;
        check_val("arst_gain", gain, 0);
        check_val("arst_tbl_sel", tbl_sel, 0);
        check_val("arst_busy", busy, 1);
        step(2);
        snap();
        reset = 1'b0;
        wait_for("arst_busy_fall", 0, 8'd0, 300, cyc);
        check_val("arst_load", n_load - b_load, 1);
        check_val("arst_tbl_sel_end", tbl_sel, 0);
        check_log("arst_gain_seq", 1'b0, b_log, 4, e_up);

        // Step 48: saturating ramps 0,48,96,128 and 128,80,32,0
        reset2 = 1'b1;
        step(3);
        snap();
        reset2 = 1'b0;
        wait_for("s48_pwr_busy_fall", 2, 8'd0, 300, cyc);
        check_log("s48_up", 1'b1, b_log2, 3, e48_up);
        snap();
        sw2 = 4'd3;
        wait_for("s48_busy_rise", 2, 8'd1, 100, cyc);
        wait_for("s48_busy_fall", 2, 8'd0, 400, cyc);
        check_val("s48_tbl_sel", tbl_sel2, 3);
        check_val("s48_load", n_load2 - b_load2, 1);
        check_log("s48_full", 1'b1, b_log2, 6, e48_full);

        check_val("load_clr_paired", n_pair, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
